mips_instr_encoder: RTL and testbench

MIPS_INSTR_ENCODER -- requirements
Module: mips_instr_encoder

---
 rtl/mips_instr_encoder.sv | 184 ++++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// ============================================================================
// Module  : mips_instr_encoder
// Brief   : Streams MIPS instruction requests into encoded 32-bit words with
//           sequential byte addresses. Optional trap word: MIPS_ENC_TRAP_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [5:0]  in_funct,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        done,
  output logic        err,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TRAP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] count_q, count_d;
`ifdef MIPS_ENC_TRAP_EN
  logic        trap_sent_q, trap_sent_d;
`endif

  logic        w_out_free;
  logic        w_hs;
  logic        w_accept;
  logic        w_legal;
  logic [31:0] w_enc;

  assign w_out_free = !out_valid_q || out_ready;
  assign w_hs       = out_valid_q && out_ready;
  assign in_ready   = (state_q == RUN) && w_out_free;
  assign w_accept   = in_valid && in_ready;
  assign w_legal    = !in_kind[3];

  always_comb begin
    w_enc = 32'h0000_0000;
    case (in_kind)
      4'd0:    w_enc = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b00000, in_funct};
      4'd1:    w_enc = {OP_ADDI, in_rs, in_rt, in_imm};
      4'd2:    w_enc = {OP_ANDI, in_rs, in_rt, in_imm};
      4'd3:    w_enc = {OP_LW,   in_rs, in_rt, in_imm};
      4'd4:    w_enc = {OP_SW,   in_rs, in_rt, in_imm};
      4'd5:    w_enc = {OP_BEQ,  in_rs, in_rt, in_imm};
      4'd6:    w_enc = {OP_BNE,  in_rs, in_rt, in_imm};
      4'd7:    w_enc = {OP_J,    in_target};
      default: w_enc = 32'h0000_0000;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    done_d      = done_q;
    err_d       = err_q;
`ifdef MIPS_ENC_TRAP_EN
    trap_sent_d = trap_sent_q;
`endif
    // out_addr always names the word in (or next loaded into) the output register
    out_addr_d  = w_hs ? out_addr_q + 32'd4 : out_addr_q;
    count_d     = (w_hs && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;

    if (w_hs) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      RUN: begin
        if (w_accept) begin
          if (w_legal) begin
            out_valid_d = 1'b1;
            out_instr_d = w_enc;
          end else begin
            err_d = 1'b1;
          end
          if (in_last) begin
            state_d = TRAP;
`ifdef MIPS_ENC_TRAP_EN
            trap_sent_d = 1'b0;
`endif
          end
        end
      end
      TRAP: begin
`ifdef MIPS_ENC_TRAP_EN
        if (!trap_sent_q) begin
          if (w_out_free) begin
            out_valid_d = 1'b1;
            out_instr_d = {OP_J, out_addr_d[27:2]};
            trap_sent_d = 1'b1;
          end
        end else if (w_out_free) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
`else
        // Drain only: finish once the last word has left the output register
        if (w_out_free) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0000_0000;
      out_addr_q  <= BASE_ADDR;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= 16'h0000;
`ifdef MIPS_ENC_TRAP_EN
      trap_sent_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      done_q      <= done_d;
      err_q       <= err_d;
      count_q     <= count_d;
`ifdef MIPS_ENC_TRAP_EN
      trap_sent_q <= trap_sent_d;
`endif
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_addr    = out_addr_q;
  assign done        = done_q;
  assign err         = err_q;
  assign instr_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
// ============================================================================
// Module  : tb_mips_instr_encoder
// Brief   : Directed self-checking bench for mips_instr_encoder.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_instr_encoder;

`ifdef MIPS_ENC_TRAP_EN
  localparam logic [31:0] BASE = 32'h0000_0040;
`else
  localparam logic [31:0] BASE = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        done;
  logic        err;
  logic [15:0] instr_count;

  int tests = 0;
  int fails = 0;

  mips_instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .done(done), .err(err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic last);
    in_valid  = 1'b1;
    in_kind   = k;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_funct  = f;
    in_imm    = imm;
    in_target = tgt;
    in_last   = last;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL reset_instr got %h exp 0", out_instr); end
    tests++; if (out_addr !== BASE) begin fails++; $display("FAIL reset_addr got %h exp %h", out_addr, BASE); end
    tests++; if (instr_count !== 16'h0) begin fails++; $display("FAIL reset_count got %0d exp 0", instr_count); end
    tests++; if ({done, err} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b exp 00", {done, err}); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    drive(4'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0);
    tick();
    idle();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL addi_valid got %b exp 1", out_valid); end
    tests++; if (out_instr !== 32'h2043_0005) begin fails++; $display("FAIL addi_instr got %h exp 20430005", out_instr); end
    tests++; if (out_addr !== BASE) begin fails++; $display("FAIL addi_addr got %h exp %h", out_addr, BASE); end
    tick();
    tests++; if (instr_count !== 16'd1) begin fails++; $display("FAIL addi_count got %0d exp 1", instr_count); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL addi_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(4'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'd0, 1'b0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tests++; if (out_valid !== 1'b1 || out_instr !== 32'h0022_1820 || out_addr !== BASE + 32'd4) begin
        fails++; $display("FAIL stall_hold[%0d] got v=%b %h @%h exp v=1 00221820 @%h", i, out_valid, out_instr, out_addr, BASE + 32'd4);
      end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_ready[%0d] got %b exp 0", i, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready got %b exp 1", in_ready); end
    tick();
    tests++; if (instr_count !== 16'd2 || out_addr !== BASE + 32'd8) begin
      fails++; $display("FAIL stall_after got cnt=%0d @%h exp cnt=2 @%h", instr_count, out_addr, BASE + 32'd8);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1;
    drive(4'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0);
    tick();
    tests++; if (out_instr !== 32'h8C22_0004 || out_addr !== BASE) begin
      fails++; $display("FAIL ill_lw1 got %h @%h exp 8c220004 @%h", out_instr, out_addr, BASE);
    end
    drive(4'd9, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hFFFF, 26'd0, 1'b0);
    tick();
    tests++; if (err !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL ill_err got err=%b v=%b exp err=1 v=0", err, out_valid);
    end
    tests++; if (instr_count !== 16'd1 || out_addr !== BASE + 32'd4) begin
      fails++; $display("FAIL ill_nochange got cnt=%0d @%h exp cnt=1 @%h", instr_count, out_addr, BASE + 32'd4);
    end
    drive(4'd3, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0008, 26'd0, 1'b0);
    tick();
    idle();
    tests++; if (out_valid !== 1'b1 || out_instr !== 32'h8C64_0008 || out_addr !== BASE + 32'd4) begin
      fails++; $display("FAIL ill_lw2 got v=%b %h @%h exp v=1 8c640008 @%h", out_valid, out_instr, out_addr, BASE + 32'd4);
    end
    tick();
    tests++; if (instr_count !== 16'd2 || err !== 1'b1) begin
      fails++; $display("FAIL ill_end got cnt=%0d err=%b exp cnt=2 err=1", instr_count, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  k   [7];
    logic [4:0]  rs  [7];
    logic [15:0] imm [7];
    logic [31:0] exp [7];
    k[0] = 4'd2; rs[0] = 5'd5;  imm[0] = 16'hFFFF; exp[0] = 32'h30A6_FFFF;
    k[1] = 4'd4; rs[1] = 5'd29; imm[1] = 16'h8000; exp[1] = 32'hAFBF_8000;
    k[2] = 4'd5; rs[2] = 5'd1;  imm[2] = 16'hFFFE; exp[2] = 32'h1022_FFFE;
    k[3] = 4'd6; rs[3] = 5'd1;  imm[3] = 16'h0003; exp[3] = 32'h1422_0003;
    k[4] = 4'd7; rs[4] = 5'd0;  imm[4] = 16'h0000; exp[4] = 32'h0BFF_FFFF;
    k[5] = 4'd0; rs[5] = 5'd31; imm[5] = 16'h0000; exp[5] = 32'h03FF_F83F;
    k[6] = 4'd1; rs[6] = 5'd0;  imm[6] = 16'h0001; exp[6] = 32'h2002_0001;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      // rt per entry: andi 6, sw 31, beq/bne 2, j 0, R 31, addi 2
      drive(k[i], rs[i], (i == 0) ? 5'd6 : (i == 1 || i == 5) ? 5'd31 : (i == 4) ? 5'd0 : 5'd2,
            5'd31, 6'h3F, imm[i], 26'h3FF_FFFF, 1'b0);
      if (i > 0) begin
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, in_ready); end
      end
      tick();
      tests++; if (out_valid !== 1'b1 || out_instr !== exp[i] || out_addr !== BASE + 32'(4 * i)) begin
        fails++; $display("FAIL b2b_word[%0d] got v=%b %h @%h exp v=1 %h @%h", i, out_valid, out_instr, out_addr, exp[i], BASE + 32'(4 * i));
      end
    end
    idle();
    tick();
    tests++; if (instr_count !== 16'd7 || out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_count got cnt=%0d v=%b exp cnt=7 v=0", instr_count, out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    drive(4'd12, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'd0, 1'b0);
    tick();
    drive(4'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0);
    tick();
    idle();
    tests++; if (out_valid !== 1'b1 || err !== 1'b1) begin
      fails++; $display("FAIL mid_pre got v=%b err=%b exp v=1 err=1", out_valid, err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (out_valid !== 1'b0 || out_addr !== BASE || instr_count !== 16'd0 || err !== 1'b0) begin
      fails++; $display("FAIL mid_reset got v=%b @%h cnt=%0d err=%b exp v=0 @%h cnt=0 err=0", out_valid, out_addr, instr_count, err, BASE);
    end
    out_ready = 1'b1;
    tick();
    tests++; if (instr_count !== 16'd0) begin fails++; $display("FAIL mid_discard got cnt=%0d exp 0", instr_count); end
  endtask

`ifdef MIPS_ENC_TRAP_EN
  task automatic test_trap();
    do_reset();
    out_ready = 1'b1;
    drive(4'd4, 5'd29, 5'd31, 5'd0, 6'd0, 16'h8000, 26'd0, 1'b1);
    tick();
    drive(4'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0);
    tests++; if (out_instr !== 32'hAFBF_8000 || out_addr !== 32'h40 || in_ready !== 1'b0) begin
      fails++; $display("FAIL trap_sw got %h @%h rdy=%b exp afbf8000 @40 rdy=0", out_instr, out_addr, in_ready);
    end
    tick();
    tests++; if (out_valid !== 1'b1 || out_instr !== 32'h0800_0011 || out_addr !== 32'h44 || done !== 1'b0) begin
      fails++; $display("FAIL trap_word got v=%b %h @%h done=%b exp v=1 08000011 @44 done=0", out_valid, out_instr, out_addr, done);
    end
    tick();
    tests++; if (done !== 1'b1 || in_ready !== 1'b0 || instr_count !== 16'd2 || out_valid !== 1'b0) begin
      fails++; $display("FAIL trap_done got done=%b rdy=%b cnt=%0d v=%b exp 1 0 2 0", done, in_ready, instr_count, out_valid);
    end
    tick();
    tick();
    idle();
    tests++; if (done !== 1'b1 || instr_count !== 16'd2 || out_valid !== 1'b0) begin
      fails++; $display("FAIL trap_hold got done=%b cnt=%0d v=%b exp 1 2 0", done, instr_count, out_valid);
    end
  endtask
`else
  task automatic test_last_no_trap();
    do_reset();
    out_ready = 1'b1;
    drive(4'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFE, 26'd0, 1'b1);
    tick();
    drive(4'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0);
    tests++; if (out_instr !== 32'h1022_FFFE || in_ready !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL last_beq got %h rdy=%b done=%b exp 1022fffe 0 0", out_instr, in_ready, done);
    end
    tick();
    tests++; if (done !== 1'b1 || in_ready !== 1'b0 || instr_count !== 16'd1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL last_done got done=%b rdy=%b cnt=%0d v=%b exp 1 0 1 0", done, in_ready, instr_count, out_valid);
    end
    tick();
    tick();
    idle();
    tests++; if (done !== 1'b1 || instr_count !== 16'd1 || out_valid !== 1'b0 || out_addr !== BASE + 32'd4) begin
      fails++; $display("FAIL last_hold got done=%b cnt=%0d v=%b @%h exp 1 1 0 @%h", done, instr_count, out_valid, out_addr, BASE + 32'd4);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_kind   = 4'd0;
    in_rs     = 5'd0;
    in_rt     = 5'd0;
    in_rd     = 5'd0;
    in_funct  = 6'd0;
    in_imm    = 16'd0;
    in_target = 26'd0;
    in_last   = 1'b0;
    test_reset();
    test_addi();
    test_stall();
    test_illegal();
    test_back_to_back();
    test_reset_midflight();
`ifdef MIPS_ENC_TRAP_EN
    test_trap();
`else
    test_last_no_trap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
